// File: rtl/fetch_unit.sv
// fetch_unit: rv32i fetch stage with credit-limited imem requests and in-order response queue; define RV32I_FETCH_MISALIGN_CHECK_EN to fault on misaligned redirects
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fetch_fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = DEPTH[CW:0];
  logic run;
  logic fault;
  logic accept;
  logic push;
  logic pop;
  logic drop;
  logic [31:0] pc_fetch;
  logic [31:0] pc_resp;
  logic [31:0] target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [CW-1:0] rsp;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc [DEPTH];
  assign rsp = CW'(imem_rvalid);
  // Pops do not free credit until the next cycle, so the queue can never overflow.
  assign imem_req = run && !redirect && !fault && ({1'b0, outstanding} + {1'b0, count} < LIMIT);
  assign imem_addr = pc_fetch;
  assign accept = imem_req && imem_ready;
  assign drop = imem_rvalid && discard != '0;
  assign push = imem_rvalid && !redirect && discard == '0;
  assign out_valid = count != '0 && !redirect;
  assign pop = out_valid && out_ready;
  assign out_instr = q_instr[rd_ptr];
  assign out_pc = q_pc[rd_ptr];
  assign fetch_fault = fault;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= 1'b0;
      pc_fetch <= RESET_PC;
      pc_resp <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i] <= '0;
      end
    end else begin
      run <= 1'b1;
      if (redirect) begin
        pc_fetch <= target;
        pc_resp <= target;
        outstanding <= outstanding - rsp;
        discard <= outstanding - rsp;
        count <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (accept)
          pc_fetch <= pc_fetch + 32'd4;
        outstanding <= outstanding + CW'(accept) - rsp;
        if (drop)
          discard <= discard - CW'(1);
        if (push) begin
          q_instr[wr_ptr] <= imem_rdata;
          q_pc[wr_ptr] <= pc_resp;
          wr_ptr <= wr_ptr + AW'(1);
          pc_resp <= pc_resp + 32'd4;
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
`ifdef RV32I_FETCH_MISALIGN_CHECK_EN
  assign target = redirect_pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      fault <= 1'b0;
    else if (redirect)
      fault <= redirect_pc[1:0] != 2'b00;
`else
  assign target = redirect_pc & 32'hFFFF_FFFC;
  assign fault = 1'b0;
`endif
endmodule
